// File: rtl/fp_mult_round_pack_ctrl.sv
`timescale 1ns/1ps
// FP multiplier back end: exponent add, 1-bit normalize, round-nearest-even,
// overflow/underflow classification, IEEE pack and output-stage load sequencing.
module fp_mult_round_pack_ctrl #(
    parameter int W  = 32,
    parameter int EW = (W == 64) ? 11 : 8,
    parameter int SW = (W == 64) ? 52 : 23
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            sign_x,
    input  logic            sign_y,
    input  logic [EW-1:0]   exp_x,
    input  logic [EW-1:0]   exp_y,
    input  logic [2*SW+1:0] sgf_prod,
    output logic [W-1:0]    ieee_result,
    output logic            load_a,
    output logic            load_b,
    output logic            selector_a,
    output logic            selector_b,
    output logic            ready
);

    localparam int EE = EW + 2;
    localparam logic signed [EE-1:0] BIAS = EE'((1 << (EW - 1)) - 1);
    localparam logic signed [EE-1:0] EMAX = EE'((1 << EW) - 1);
    localparam logic signed [EE-1:0] EZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE, S_EXP, S_NORM, S_ROUND, S_CHECK, S_LOADB, S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_sign;
    logic [EW-1:0]          r_ex;
    logic [EW-1:0]          r_ey;
    logic [2*SW+1:0]        r_prod;
    logic signed [EE-1:0]   r_e;
    logic                   r_zero;
    logic                   r_inf;
    logic [SW:0]            r_m;
    logic                   r_g;
    logic                   r_s;
    logic [W-1:0]           r_ieee;
    logic                   r_load_a;
    logic                   r_load_b;
    logic                   r_sel_a;
    logic                   r_sel_b;
    logic                   r_ready;

    logic signed [EE-1:0]   w_e_sum;
    logic                   w_top;
    logic [SW:0]            w_nm;
    logic                   w_ng;
    logic                   w_ns;
    logic signed [EE-1:0]   w_ne;
    logic                   w_rup;
    logic                   w_carry;
    logic [SW-1:0]          w_frac;
    logic signed [EE-1:0]   w_re;
    logic                   w_ovf;
    logic                   w_unf;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_EXP;
            S_EXP:   w_next = S_NORM;
            S_NORM:  w_next = S_ROUND;
            S_ROUND: w_next = S_CHECK;
            S_CHECK: w_next = S_LOADB;
            S_LOADB: w_next = S_DONE;
            S_DONE:  if (!start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_e_sum = $signed({2'b00, r_ex}) + $signed({2'b00, r_ey}) - BIAS;

    assign w_top = r_prod[2*SW+1];
    assign w_nm  = w_top ? r_prod[2*SW+1:SW+1] : r_prod[2*SW:SW];
    assign w_ng  = w_top ? r_prod[SW] : r_prod[SW-1];
    assign w_ns  = w_top ? |r_prod[SW-1:0] : |r_prod[SW-2:0];
    assign w_ne  = r_e + $signed({{(EE-1){1'b0}}, w_top});

    // An all-ones significand that rounds up wraps the fraction to zero,
    // which is exactly the renormalized 1.000...0 once e is bumped.
    assign w_rup   = r_g & (r_s | r_m[0]);
    assign w_carry = (&r_m) & w_rup;
    assign w_frac  = r_m[SW-1:0] + SW'(w_rup);
    assign w_re    = r_e + $signed({{(EE-1){1'b0}}, w_carry});

    assign w_ovf = !r_zero && (r_inf || w_re >= EMAX);
    assign w_unf = !w_ovf && (r_zero || w_re <= EZERO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign   <= 1'b0;
            r_ex     <= '0;
            r_ey     <= '0;
            r_prod   <= '0;
            r_e      <= '0;
            r_zero   <= 1'b0;
            r_inf    <= 1'b0;
            r_m      <= '0;
            r_g      <= 1'b0;
            r_s      <= 1'b0;
            r_ieee   <= '0;
            r_load_a <= 1'b0;
            r_load_b <= 1'b0;
            r_sel_a  <= 1'b0;
            r_sel_b  <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign <= sign_x ^ sign_y;
                        r_ex   <= exp_x;
                        r_ey   <= exp_y;
                        r_prod <= sgf_prod;
                    end
                end
                S_EXP: begin
                    r_e    <= w_e_sum;
                    r_zero <= (r_ex == '0) || (r_ey == '0);
                    r_inf  <= (&r_ex) || (&r_ey);
                end
                S_NORM: begin
                    r_m <= w_nm;
                    r_g <= w_ng;
                    r_s <= w_ns;
                    r_e <= w_ne;
                end
                S_ROUND: begin
                    r_e      <= w_re;
                    r_ieee   <= {r_sign, w_re[EW-1:0], w_frac};
                    r_sel_a  <= w_ovf;
                    r_sel_b  <= !(w_ovf || w_unf);
                    r_load_a <= 1'b1;
                end
                S_CHECK: begin
                    r_load_a <= 1'b0;
                    r_load_b <= 1'b1;
                end
                S_LOADB: begin
                    r_load_b <= 1'b0;
                    r_ready  <= 1'b1;
                end
                S_DONE: begin
                    if (!start) r_ready <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ieee_result = r_ieee;
    assign load_a      = r_load_a;
    assign load_b      = r_load_b;
    assign selector_a  = r_sel_a;
    assign selector_b  = r_sel_b;
    assign ready       = r_ready;

endmodule

// File: tb/tb_fp_mult_round_pack_ctrl.sv
`timescale 1ns/1ps
// Bench for fp_mult_round_pack_ctrl: vector table, control corners,
// randomized ops against an arithmetic rounding model, and a 64-bit instance.
module tb_fp_mult_round_pack_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        st, sx, sy;
    logic [7:0]  ex, ey;
    logic [47:0] prod;
    logic [31:0] ieee;
    logic        la, lb, sa, sb, rdy;

    logic         st6, sx6, sy6;
    logic [10:0]  ex6, ey6;
    logic [105:0] prod6;
    logic [63:0]  ieee6;
    logic         la6, lb6, sa6, sb6, rdy6;

    fp_mult_round_pack_ctrl #(.W(32)) u32 (
        .clk(clk), .rst(rst), .start(st), .sign_x(sx), .sign_y(sy),
        .exp_x(ex), .exp_y(ey), .sgf_prod(prod), .ieee_result(ieee),
        .load_a(la), .load_b(lb), .selector_a(sa), .selector_b(sb),
        .ready(rdy)
    );

    fp_mult_round_pack_ctrl #(.W(64)) u64 (
        .clk(clk), .rst(rst), .start(st6), .sign_x(sx6), .sign_y(sy6),
        .exp_x(ex6), .exp_y(ey6), .sgf_prod(prod6), .ieee_result(ieee6),
        .load_a(la6), .load_b(lb6), .selector_a(sa6), .selector_b(sb6),
        .ready(rdy6)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output-stage word: packed result, or the signed inf/zero exception word.
    function automatic logic [31:0] f32(input logic [31:0] w,
                                        input logic a, input logic b);
        if (b) return w;
        return {w[31], a ? 8'hFF : 8'h00, 23'h0};
    endfunction

    function automatic logic [63:0] f64(input logic [63:0] w,
                                        input logic a, input logic b);
        if (b) return w;
        return {w[63], a ? 11'h7FF : 11'h000, 52'h0};
    endfunction

    task automatic ref32(input logic s_x, input logic s_y,
                         input logic [7:0] e_x, input logic [7:0] e_y,
                         input logic [47:0] p_in,
                         output logic [31:0] f, output logic o_a,
                         output logic o_b);
        logic [63:0] p, q, r, half;
        int e, sh;
        bit zero, inf, ovf, unf, s;
        logic [31:0] packed_w;
        logic [7:0] e8;
        s    = s_x ^ s_y;
        e    = int'(e_x) + int'(e_y) - 127;
        p    = 64'(p_in);
        sh   = (p >= 64'd1 << 47) ? 24 : 23;
        q    = p >> sh;
        r    = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (r > half || (r == half && q[0])) q = q + 1;
        e = e + sh - 23;
        if (q == 64'd1 << 24) begin
            q = q >> 1;
            e = e + 1;
        end
        zero = (e_x == 0) || (e_y == 0);
        inf  = (e_x == 8'hFF) || (e_y == 8'hFF);
        ovf  = !zero && (inf || e >= 255);
        unf  = !ovf && (zero || e <= 0);
        e8   = 8'(e);
        packed_w = {s, e8, q[22:0]};
        o_a = ovf;
        o_b = !(ovf || unf);
        f   = f32(packed_w, o_a, o_b);
    endtask

    logic [31:0] r_f;
    logic        r_sa, r_sb;
    int          t_la, t_lb, t_rdy, n_la, n_lb, n_ovl;

    task automatic run32(input logic s_x, input logic s_y,
                         input logic [7:0] e_x, input logic [7:0] e_y,
                         input logic [47:0] p_in,
                         input bit pulse_round, input int hold);
        logic [31:0] wa;
        wa = '0;
        t_la = -1; t_lb = -1; t_rdy = -1;
        n_la = 0; n_lb = 0; n_ovl = 0;
        r_sa = 1'b0; r_sb = 1'b0;
        @(negedge clk);
        sx = s_x; sy = s_y; ex = e_x; ey = e_y; prod = p_in; st = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(posedge clk);
            #1;
            if (c == 1) begin
                if (hold == 0) st = 1'b0;
                ex = ~ex; ey = ey + 8'd3; prod = ~prod;
            end
            if (pulse_round && c == 3) st = 1'b1;
            if (pulse_round && c == 4) st = 1'b0;
            if (la && lb) n_ovl++;
            if (la) n_la++;
            if (lb) n_lb++;
            if (la && t_la < 0) begin
                t_la = c;
                wa = ieee;
            end
            if (lb && t_lb < 0) begin
                t_lb = c;
                r_sa = sa;
                r_sb = sb;
            end
            if (rdy && t_rdy < 0) t_rdy = c;
            if (t_rdy >= 0) break;
        end
        if (t_rdy < 0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready expected ready by 12");
        end
        if (hold > 0) begin
            int bad;
            bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (!rdy || la || lb) bad++;
            end
            chk("hold_ready", 64'(bad), 64'd0);
            st = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ready_drop", 64'(rdy), 64'd0);
        r_f = f32(wa, r_sa, r_sb);
    endtask

    typedef struct {
        logic        sx, sy;
        logic [7:0]  ex, ey;
        logic [47:0] prod;
        logic [31:0] f;
        logic        sa, sb;
    } vec_t;

    vec_t vt[12];

    initial begin
        logic [31:0] ef, held;
        logic        ea, eb;
        logic [47:0] rp;
        int          act;

        st = 0; sx = 0; sy = 0; ex = 0; ey = 0; prod = '0;
        st6 = 0; sx6 = 0; sy6 = 0; ex6 = 0; ey6 = 0; prod6 = '0;

        vt[0]  = '{0, 0, 127, 128, 48'h600000000000, 32'h40400000, 0, 1};
        vt[1]  = '{0, 0, 127, 127, 48'h800001800000, 32'h40000002, 0, 1};
        vt[2]  = '{0, 0, 127, 127, 48'h800000800000, 32'h40000000, 0, 1};
        vt[3]  = '{0, 0, 127, 127, 48'hFFFFFF800000, 32'h40800000, 0, 1};
        vt[4]  = '{1, 0, 254, 254, 48'h400000000000, 32'hFF800000, 1, 0};
        vt[5]  = '{1, 0, 1,   1,   48'h400000000000, 32'h80000000, 0, 0};
        vt[6]  = '{0, 0, 0,   255, 48'h400000000000, 32'h00000000, 0, 0};
        vt[7]  = '{1, 1, 255, 1,   48'h400000000000, 32'h7F800000, 1, 0};
        vt[8]  = '{0, 0, 127, 254, 48'h400000000000, 32'h7F000000, 0, 1};
        vt[9]  = '{0, 0, 127, 254, 48'h800000000000, 32'h7F800000, 1, 0};
        vt[10] = '{0, 0, 63,  64,  48'h800000000000, 32'h00800000, 0, 1};
        vt[11] = '{0, 0, 63,  64,  48'h400000000000, 32'h00000000, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset32", {26'h0, ieee, la, lb, sa, sb, rdy, 1'b0}, 64'd0);
        chk("reset64_w", ieee6, 64'd0);
        chk("reset64_c", {59'h0, la6, lb6, sa6, sb6, rdy6}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run32(vt[i].sx, vt[i].sy, vt[i].ex, vt[i].ey, vt[i].prod, 0, 0);
            chk($sformatf("vec%0d_word", i), 64'(r_f), 64'(vt[i].f));
            chk($sformatf("vec%0d_sel", i), {62'h0, r_sa, r_sb},
                {62'h0, vt[i].sa, vt[i].sb});
            chk($sformatf("vec%0d_timing", i),
                {16'h0, 8'(t_la), 8'(t_lb), 8'(t_rdy), 8'(n_la), 8'(n_lb),
                 8'(n_ovl)},
                {16'h0, 8'd4, 8'd5, 8'd6, 8'd1, 8'd1, 8'd0});
        end

        run32(vt[0].sx, vt[0].sy, vt[0].ex, vt[0].ey, vt[0].prod, 1, 0);
        chk("pulse_round_word", 64'(r_f), 64'(vt[0].f));
        chk("pulse_round_timing", {40'h0, 8'(t_la), 8'(t_lb), 8'(t_rdy)},
            {40'h0, 8'd4, 8'd5, 8'd6});
        held = ieee;
        act = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            act += int'(la | lb | rdy);
        end
        chk("pulse_round_idle", 64'(act), 64'd0);
        chk("idle_hold_word", 64'(ieee), 64'(held));
        chk("idle_hold_sel", {62'h0, sa, sb}, {62'h0, 1'b0, 1'b1});

        run32(vt[1].sx, vt[1].sy, vt[1].ex, vt[1].ey, vt[1].prod, 0, 5);
        chk("hold_word", 64'(r_f), 64'(vt[1].f));
        chk("hold_n_load", {48'h0, 8'(n_la), 8'(n_lb)}, {48'h0, 8'd1, 8'd1});

        @(negedge clk);
        sx = 0; sy = 0; ex = 127; ey = 128; prod = 48'h600000000000;
        st = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_async", {26'h0, ieee, la, lb, sa, sb, rdy, 1'b0}, 64'd0);
        act = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            act += int'(la | lb | rdy);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            act += int'(la | lb | rdy);
        end
        chk("rst_abort", 64'(act), 64'd0);
        run32(vt[3].sx, vt[3].sy, vt[3].ex, vt[3].ey, vt[3].prod, 0, 0);
        chk("post_rst_word", 64'(r_f), 64'(vt[3].f));
        chk("post_rst_timing", {40'h0, 8'(t_la), 8'(t_lb), 8'(t_rdy)},
            {40'h0, 8'd4, 8'd5, 8'd6});

        for (int n = 0; n < 200; n++) begin
            logic rsx, rsy;
            logic [7:0] rex, rey;
            rsx = 1'($urandom);
            rsy = 1'($urandom);
            rex = 8'($urandom);
            rey = 8'($urandom);
            if ($urandom_range(0, 9) == 0) rex = 8'd0;
            if ($urandom_range(0, 9) == 0) rey = 8'hFF;
            rp = {16'($urandom), 32'($urandom)};
            if (rp[47:46] == 2'b00) rp[46] = 1'b1;
            case ($urandom_range(0, 3))
                0: rp[23:0] = 24'h800000;
                1: rp[22:0] = 23'h400000;
                default: ;
            endcase
            ref32(rsx, rsy, rex, rey, rp, ef, ea, eb);
            run32(rsx, rsy, rex, rey, rp, 0, 0);
            chk($sformatf("rand%0d_word", n), 64'(r_f), 64'(ef));
            chk($sformatf("rand%0d_sel", n), {62'h0, r_sa, r_sb},
                {62'h0, ea, eb});
        end

        for (int k = 0; k < 2; k++) begin
            logic [63:0] w64, ef64;
            logic a64, b64;
            int tl;
            w64 = '0; a64 = 0; b64 = 0; tl = -1;
            @(negedge clk);
            sx6 = 0; sy6 = 0;
            ex6 = (k == 0) ? 11'd1023 : 11'd2046;
            ey6 = ex6;
            prod6 = 106'(1) << 104;
            st6 = 1'b1;
            @(posedge clk);
            #1;
            st6 = 1'b0;
            for (int c = 2; c <= 12; c++) begin
                @(posedge clk);
                #1;
                if (la6) begin
                    w64 = ieee6;
                    tl = c;
                end
                if (lb6) begin
                    a64 = sa6;
                    b64 = sb6;
                end
                if (rdy6) break;
            end
            ef64 = (k == 0) ? 64'h3FF0000000000000 : 64'h7FF0000000000000;
            chk($sformatf("w64_%0d_word", k), f64(w64, a64, b64), ef64);
            chk($sformatf("w64_%0d_la", k), 64'(tl), 64'd4);
            if (k == 0) chk("w64_raw", w64, 64'h3FF0000000000000);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_round_pack_ctrl.md
Name: fp_mult_round_pack_ctrl

Overview:
Final arithmetic and control stage of the FP multiplier, directly upstream of the output-select/register stage. It takes the operand signs, biased exponents and the raw significand product, then:
- adds the exponents and removes the bias,
- normalizes by 1 bit,
- rounds to nearest-even,
- classifies overflow/underflow,
- packs the IEEE word.

It also sequences load_a, load_b, selector_a and selector_b for the output stage.

Parameters:
W, 32, word width; only 32 or 64 are legal.
EW, 8 (11 when W=64), exponent width.
SW, 23 (52 when W=64), stored fraction width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  operands valid; sampled only in IDLE
sign_x  in  1  sign of X
sign_y  in  1  sign of Y
exp_x  in  EW  biased exponent of X
exp_y  in  EW  biased exponent of Y
sgf_prod  in  2*SW+2  unsigned product of the 1.f significands
ieee_result  out  W  packed result {sign, exp, frac}
load_a  out  1  1-cycle pulse: output stage captures ieee_result
load_b  out  1  1-cycle pulse: output stage captures the selected word
selector_a  out  1  1 = overflow word, 0 = underflow word
selector_b  out  1  1 = normal packed result, 0 = exception word
ready  out  1  result committed downstream

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. ieee_result, load_a, load_b, selector_a, selector_b and ready are all 0. Internal registers are cleared. Reset during any state aborts the operation with no further pulses.
- FSM states: IDLE -> EXP -> NORM -> ROUND -> CHECK -> LOADB -> DONE -> IDLE. One cycle per state except IDLE and DONE.
- IDLE:
  - On start=1, register all inputs and compute sign = sign_x ^ sign_y; go to EXP.
  - start=0 stays in IDLE.
- EXP:
  - e = exp_x + exp_y - (2^(EW-1)-1), computed as an EW+2-bit signed value.
  - Operand class flags: zero if either exponent = 0 (subnormals are treated as zero); inf if either exponent = all ones (NaN is not preserved).
- NORM:
  - If sgf_prod[2SW+1]=1: m = sgf_prod[2SW+1:SW+1], guard = sgf_prod[SW], sticky = OR(sgf_prod[SW-1:0]), e = e+1.
  - Otherwise: m = sgf_prod[2SW:SW], guard = sgf_prod[SW-1], sticky = OR(sgf_prod[SW-2:0]).
- ROUND:
  - Round-nearest-even: round up when guard & (sticky | m[0]).
  - If the increment carries out of SW+1 bits, set m = 1.000…0 and e = e+1.
- CHECK:
  - overflow = inf flag OR e >= 2^EW-1.
  - underflow = NOT overflow AND (zero flag OR e <= 0). The zero flag has priority over inf; 0*inf gives underflow.
  - ieee_result = {sign, e[EW-1:0], m[SW-1:0]}.
  - selector_b = NOT(overflow OR underflow); selector_a = overflow.
  - load_a = 1 for this cycle only.
- LOADB: load_b = 1 for this cycle only. This is exactly one cycle after load_a, so the output stage's D1 register is already valid.
- DONE:
  - ready = 1, held while start=1.
  - When start=0, go to IDLE and drop ready the same cycle.
- Selectors and ieee_result hold from CHECK until the next operation's CHECK. They are not changed on return to IDLE.
- start asserted outside IDLE is ignored. A new operation needs start low in DONE, then high in IDLE.
- Latency: start seen at cycle 0 -> load_a at cycle 4, load_b at cycle 5, ready at cycle 6. The downstream F_ieee_result is valid from cycle 6.
- load_a and load_b are never high simultaneously.

Test Plan:
1. Normal case, W=32: exp 127/128, sgf_prod=0x600000000000, signs 0/0 -> ieee_result=0x40400000, selector_b=1, load_a @4, load_b @5, ready @6.
2. Rounding, exp 127/127:
   - sgf_prod=0x800001800000 -> 0x40000002 (round up).
   - sgf_prod=0x800000800000 -> 0x40000000 (tie to even).
   - sgf_prod=0xFFFFFF800000 -> 0x40800000 (carry-out renormalize).
3. Overflow: exp 254/254, signs 1/0 -> selector_b=0, selector_a=1; downstream F_ieee_result=0xFF800000.
4. Underflow and zero:
   - exp 1/1, signs 1/0 -> selector_b=0, selector_a=0, F=0x80000000.
   - exp_x=0 with exp_y=255 -> underflow path, F=0x00000000 for signs 0/0.
5. Control:
   - rst low at NORM -> all outputs 0 and no load pulse; the next start completes normally.
   - start pulsed during ROUND -> ignored.
   - start held through DONE -> ready stays 1 with no re-launch until start drops.
6. W=64, exp 1023/1023, sgf_prod MSB=0 with only bit 104 set -> ieee_result=0x3FF0000000000000; overflow case -> F=0x7FF0000000000000.
